// File: rtl/difftest_commit_monitor.sv
// difftest_commit_monitor
//   N-wide commit monitor between the core writeback debug ports and the
//   Difftest blocks. Qualifies each slot's commit, registers it for one
//   cycle, keeps 64-bit cycle/instruction counters, and freezes on the trap
//   instruction, exporting the trap code (a0[7:0]) and trap PC.
//
// Optional feature: define DIFF_TIMEOUT_EN to add an idle watchdog that
//   raises a trap with code 8'hFF after TIMEOUT commit-free RUN cycles.
//   The port list is the same in both builds.
//
// Ports
//   clock, reset        posedge clock, synchronous active-high reset
//   wb_*                per-slot writeback debug inputs (slot 0 = oldest)
//   a0_value            architectural x10, sampled as the trap code
//   cmt_*               registered per-slot commit outputs (1-cycle latency)
//   trap/trap_code/trap_pc  sticky trap flag and its code/PC
//   cycle_cnt/instr_cnt 64-bit RUN-cycle and committed-instruction counters
module difftest_commit_monitor #(
  parameter int               NCOMMIT     = 2,
  parameter int               XLEN        = 64,
  parameter logic [XLEN-1:0]  PC_START    = XLEN'(64'h8000_0000),
  parameter logic [6:0]       TRAP_OPCODE = 7'h6b,
  parameter int               TIMEOUT     = 5000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NCOMMIT-1:0]        wb_valid,
  input  logic [NCOMMIT*XLEN-1:0]   wb_pc,
  input  logic [NCOMMIT*32-1:0]     wb_inst,
  input  logic [NCOMMIT-1:0]        wb_rf_we,
  input  logic [NCOMMIT*5-1:0]      wb_rf_wnum,
  input  logic [NCOMMIT*XLEN-1:0]   wb_rf_wdata,
  input  logic [XLEN-1:0]           a0_value,
  output logic [NCOMMIT-1:0]        cmt_valid,
  output logic [NCOMMIT*XLEN-1:0]   cmt_pc,
  output logic [NCOMMIT*32-1:0]     cmt_inst,
  output logic [NCOMMIT-1:0]        cmt_wen,
  output logic [NCOMMIT*8-1:0]      cmt_wdest,
  output logic [NCOMMIT*XLEN-1:0]   cmt_wdata,
  output logic                      trap,
  output logic [7:0]                trap_code,
  output logic [XLEN-1:0]           trap_pc,
  output logic [63:0]               cycle_cnt,
  output logic [63:0]               instr_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] TRAPPED = 1'b1;

  if (NCOMMIT < 1 || NCOMMIT > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("difftest_commit_monitor: NCOMMIT must be 1..8 and TIMEOUT >= 1");
  end

  logic [0:0]              state_reg;
  logic                    trap_reg;
  logic [7:0]              trap_code_reg;
  logic [XLEN-1:0]         trap_pc_reg;
  logic [63:0]             cycle_cnt_reg;
  logic [63:0]             instr_cnt_reg;
  logic [XLEN-1:0]         last_pc_reg;

  logic [NCOMMIT-1:0]      q;
  logic [NCOMMIT-1:0]      is_trap;
  logic [NCOMMIT:0]        trap_seen;   // trap_seen[i]: some slot below i traps
  logic [NCOMMIT-1:0]      m;
  logic [NCOMMIT-1:0]      wen_next;
  logic [NCOMMIT*8-1:0]    wdest_next;
  logic [XLEN-1:0]         trap_pc_next;
  logic [XLEN-1:0]         last_pc_next;
  logic [3:0]              commit_count;
  logic                    any_trap;

  assign trap_seen[0] = 1'b0;

  for (genvar gi = 0; gi < NCOMMIT; gi++) begin : g_slot
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      wnum;
    assign pc   = wb_pc[gi*XLEN +: XLEN];
    assign inst = wb_inst[gi*32 +: 32];
    assign wnum = wb_rf_wnum[gi*5 +: 5];
    // A bubble carries PC_START (or 0) with inst 0 and must not count.
    assign q[gi]       = wb_valid[gi] & (((pc != PC_START) & (pc != '0)) | (inst != 32'd0));
    assign is_trap[gi] = q[gi] & (inst[6:0] == TRAP_OPCODE);
    assign trap_seen[gi+1] = trap_seen[gi] | is_trap[gi];
    // The trapping slot itself commits; younger slots are dropped.
    assign m[gi]        = q[gi] & ~trap_seen[gi];
    assign wen_next[gi] = m[gi] & wb_rf_we[gi] & (wnum != 5'd0);
    assign wdest_next[gi*8 +: 8] = {3'b000, wnum};
  end

  assign any_trap = trap_seen[NCOMMIT];

  always_comb begin
    trap_pc_next = '0;
    last_pc_next = last_pc_reg;
    commit_count = 4'd0;
    // Descending scan so the lowest trapping slot wins.
    for (int i = NCOMMIT - 1; i >= 0; i--) begin
      if (is_trap[i]) trap_pc_next = wb_pc[i*XLEN +: XLEN];
    end
    // Ascending scan so the highest committed slot ends up in last_pc.
    for (int i = 0; i < NCOMMIT; i++) begin
      if (m[i]) begin
        last_pc_next = wb_pc[i*XLEN +: XLEN];
        commit_count = commit_count + 4'd1;
      end
    end
  end

`ifdef DIFF_TIMEOUT_EN
  logic [31:0] idle_reg;
  logic        timeout_hit;
  assign timeout_hit = (commit_count == 4'd0) && ((idle_reg + 32'd1) >= 32'(TIMEOUT));
`else
  // Without the watchdog nothing consumes last_pc or the upper a0 bits.
  logic unused_last_pc;
  assign unused_last_pc = ^last_pc_reg;
`endif

  logic unused_a0;
  assign unused_a0 = ^a0_value[XLEN-1:8];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      cmt_valid     <= '0;
      cmt_pc        <= '0;
      cmt_inst      <= '0;
      cmt_wen       <= '0;
      cmt_wdest     <= '0;
      cmt_wdata     <= '0;
      trap_reg      <= 1'b0;
      trap_code_reg <= 8'd0;
      trap_pc_reg   <= '0;
      cycle_cnt_reg <= 64'd0;
      instr_cnt_reg <= 64'd0;
      last_pc_reg   <= '0;
`ifdef DIFF_TIMEOUT_EN
      idle_reg      <= 32'd0;
`endif
    end else if (state_reg == RUN) begin
      cmt_valid     <= m;
      cmt_pc        <= wb_pc;
      cmt_inst      <= wb_inst;
      cmt_wen       <= wen_next;
      cmt_wdest     <= wdest_next;
      cmt_wdata     <= wb_rf_wdata;
      cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
      instr_cnt_reg <= instr_cnt_reg + 64'(commit_count);
      last_pc_reg   <= last_pc_next;
      if (any_trap) begin
        state_reg     <= TRAPPED;
        trap_reg      <= 1'b1;
        trap_code_reg <= a0_value[7:0];
        trap_pc_reg   <= trap_pc_next;
      end
`ifdef DIFF_TIMEOUT_EN
      else if (timeout_hit) begin
        state_reg     <= TRAPPED;
        trap_reg      <= 1'b1;
        trap_code_reg <= 8'hFF;
        trap_pc_reg   <= last_pc_reg;
      end
      idle_reg <= (commit_count != 4'd0) ? 32'd0 : idle_reg + 32'd1;
`endif
    end else begin
      // Frozen: the trap commit was shown last cycle, now go quiet.
      cmt_valid <= '0;
      cmt_wen   <= '0;
    end
  end

  assign trap      = trap_reg;
  assign trap_code = trap_code_reg;
  assign trap_pc   = trap_pc_reg;
  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule
